// File: rtl/io_debounce_edge.sv
// Multi-channel board-input debouncer: synchroniser, per-channel stability counter,
// registered rise/fall pulses, sticky event flags with a shared ack, and an irq summary.
module io_debounce_edge #(
  parameter int              N_CH        = 16,
  parameter int              DB_CYCLES   = 500000,
  parameter int              SIMULATE    = 0,
  parameter int              SIM_CYCLES  = 4,
  parameter int              SYNC_STAGES = 2,
  parameter logic [N_CH-1:0] INIT_VAL    = '0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] dout,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] evt_flags,
  input  logic            evt_ack,
  output logic            irq
);

  localparam int LIMIT = (SIMULATE != 0) ? SIM_CYCLES : DB_CYCLES;
  localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  if (LIMIT < 1) begin : g_bad_limit
    $error("io_debounce_edge: debounce window must be at least one cycle");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("io_debounce_edge: synchroniser needs at least two stages");
  end

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  s;
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] cnt_d  [N_CH];
  logic [N_CH-1:0]  dout_q, dout_d;
  logic [N_CH-1:0]  rise_q, rise_d;
  logic [N_CH-1:0]  fall_q, fall_d;
  logic [N_CH-1:0]  flags_q, flags_d;
  logic             irq_q, irq_d;

  // Synchroniser chain: only the last stage is allowed to feed logic.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= INIT_VAL;
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Stability counter: a change is accepted on the LIMIT-th consecutive mismatching cycle.
  always_comb begin
    dout_d = dout_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != dout_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          dout_d[i] = s[i];
          rise_d[i] = s[i];
          fall_d[i] = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A pulse produced on the same edge as an ack keeps its flag set.
  always_comb begin
    flags_d = (flags_q & ~{N_CH{evt_ack}}) | rise_d | fall_d;
    irq_d   = |flags_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      dout_q  <= INIT_VAL;
      rise_q  <= '0;
      fall_q  <= '0;
      flags_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      flags_q <= flags_d;
      irq_q   <= irq_d;
    end
  end

  assign dout      = dout_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign evt_flags = flags_q;
  assign irq       = irq_q;

endmodule
